// File: rtl/map_fme7_pkg.sv
// Shared definitions for the FME-7 mapper family: command codes, mirroring
// encodings and save-state register indices.
package map_fme7_pkg;

  typedef enum logic [3:0] {
    CMD_CHR0, CMD_CHR1, CMD_CHR2, CMD_CHR3,
    CMD_CHR4, CMD_CHR5, CMD_CHR6, CMD_CHR7,
    CMD_PRG6, CMD_PRG8, CMD_PRGA, CMD_PRGC,
    CMD_MIRROR, CMD_IRQCTL, CMD_CNTLO, CMD_CNTHI
  } cmd_e;

  typedef enum logic [1:0] {
    MIR_VERT, MIR_HORZ, MIR_ONE0, MIR_ONE1
  } mirror_e;

  localparam logic [7:0] SS_PRG6   = 8'd8;
  localparam logic [7:0] SS_PRG8   = 8'd9;
  localparam logic [7:0] SS_PRGA   = 8'd10;
  localparam logic [7:0] SS_PRGC   = 8'd11;
  localparam logic [7:0] SS_CTRL   = 8'd12;
  localparam logic [7:0] SS_CMD    = 8'd13;
  localparam logic [7:0] SS_CNT_LO = 8'd14;
  localparam logic [7:0] SS_CNT_HI = 8'd15;
  localparam logic [7:0] SS_ID     = 8'd127;
  localparam logic [7:0] MAPPER_ID = 8'd69;

endpackage

// File: rtl/fme7_irq.sv
// FME-7 16-bit down-counter with enable/irq-enable control and pending flag.
// Byte writes and control writes take priority over the decrement/wrap.
module fme7_irq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        freeze_i,
  input  logic        ctrl_we_i,
  input  logic        lo_we_i,
  input  logic        hi_we_i,
  input  logic        st_we_i,
  input  logic [7:0]  wdat_i,
  output logic [15:0] cnt_o,
  output logic        ctrl7_o,
  output logic        ctrl0_o,
  output logic        pend_o,
  output logic        irq_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        ctrl7_q, ctrl7_d;
  logic        ctrl0_q, ctrl0_d;
  logic        pend_q, pend_d;
  logic        run, wrap;

  assign run  = ctrl7_q && !freeze_i;
  assign wrap = run && (cnt_q == '0) && !lo_we_i && !hi_we_i;

  always_comb begin
    cnt_d   = cnt_q;
    ctrl7_d = ctrl7_q;
    ctrl0_d = ctrl0_q;
    pend_d  = pend_q;
    // A byte write freezes the other byte for that edge as well.
    if (lo_we_i || hi_we_i) begin
      if (lo_we_i) cnt_d[7:0]  = wdat_i;
      if (hi_we_i) cnt_d[15:8] = wdat_i;
    end else if (run) begin
      cnt_d = cnt_q - 16'd1;
    end
    if (ctrl_we_i) begin
      ctrl7_d = wdat_i[7];
      ctrl0_d = wdat_i[0];
      pend_d  = 1'b0;
    end else if (st_we_i) begin
      ctrl7_d = wdat_i[4];
      ctrl0_d = wdat_i[3];
      pend_d  = wdat_i[2];
    end else if (wrap && ctrl0_q) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      ctrl7_q <= 1'b0;
      ctrl0_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ctrl7_q <= ctrl7_d;
      ctrl0_q <= ctrl0_d;
      pend_q  <= pend_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign ctrl7_o = ctrl7_q;
  assign ctrl0_o = ctrl0_q;
  assign pend_o  = pend_q;
  assign irq_o   = pend_q;

endmodule

// File: rtl/map_069.sv
// Mapper 69 (FME-7): PRG/CHR bank registers, mirroring, save-state port.
// Define MAP069_WRAM_EN to map work RAM into $6000-$7FFF.
module map_069
  import map_fme7_pkg::*;
#(
  parameter int unsigned PRG_AW = 19,
  parameter int unsigned CHR_AW = 18
) (
  input  logic              m2,
  input  logic              map_rst_n,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_dat,
  input  logic              cpu_rw,
  input  logic              cpu_ce,
  input  logic [13:0]       ppu_addr,
  input  logic              ppu_oe,
  input  logic              ss_act,
  input  logic              ss_we,
  input  logic [7:0]        ss_addr,
  output logic [PRG_AW-1:0] prg_addr,
  output logic [CHR_AW-1:0] chr_addr,
  output logic              rom_ce,
  output logic              ram_ce,
  output logic              ram_we,
  output logic              ciram_a10,
  output logic              ciram_ce,
  output logic              irq,
  output logic [7:0]        ss_rdat
);

  localparam int unsigned PB = PRG_AW - 13;
  localparam int unsigned CB = CHR_AW - 10;

  cmd_e       cmd_q, cmd_d;
  mirror_e    mirror_q, mirror_d;
  logic [7:0] reg8_q, reg8_d;
  logic [7:0] chr_q [8];
  logic [7:0] chr_d [8];
  logic [7:0] prg_q [3];
  logic [7:0] prg_d [3];

  logic        cpu_we, cmd_we, dat_we, ss_wr, wram_win;
  logic        ctrl_we, lo_we, hi_we, st_we;
  logic [15:0] cnt;
  logic        ctrl7, ctrl0, pend;
  logic [31:0] prg_ext, chr_ext;
  logic        unused_ok;

  assign cpu_we   = !cpu_ce && !cpu_rw && !ss_act;
  assign cmd_we   = cpu_we && (cpu_addr[14:13] == 2'd0);
  assign dat_we   = cpu_we && (cpu_addr[14:13] == 2'd1);
  assign ss_wr    = ss_act && ss_we;
  assign ctrl_we  = dat_we && (cmd_q == CMD_IRQCTL);
  assign lo_we    = (dat_we && (cmd_q == CMD_CNTLO)) || (ss_wr && (ss_addr == SS_CNT_LO));
  assign hi_we    = (dat_we && (cmd_q == CMD_CNTHI)) || (ss_wr && (ss_addr == SS_CNT_HI));
  assign st_we    = ss_wr && (ss_addr == SS_CTRL);

  always_comb begin
    cmd_d    = cmd_q;
    mirror_d = mirror_q;
    reg8_d   = reg8_q;
    chr_d    = chr_q;
    prg_d    = prg_q;
    if (cmd_we) cmd_d = cmd_e'(cpu_dat[3:0]);
    if (dat_we) begin
      case (cmd_q)
        CMD_PRG6:   reg8_d   = cpu_dat;
        CMD_PRG8:   prg_d[0] = cpu_dat;
        CMD_PRGA:   prg_d[1] = cpu_dat;
        CMD_PRGC:   prg_d[2] = cpu_dat;
        CMD_MIRROR: mirror_d = mirror_e'(cpu_dat[1:0]);
        CMD_IRQCTL, CMD_CNTLO, CMD_CNTHI: ;
        default:    chr_d[cmd_q[2:0]] = cpu_dat;
      endcase
    end
    if (ss_wr) begin
      if (ss_addr < 8'd8) begin
        chr_d[ss_addr[2:0]] = cpu_dat;
      end else begin
        case (ss_addr)
          SS_PRG6: reg8_d   = cpu_dat;
          SS_PRG8: prg_d[0] = cpu_dat;
          SS_PRGA: prg_d[1] = cpu_dat;
          SS_PRGC: prg_d[2] = cpu_dat;
          SS_CTRL: mirror_d = mirror_e'(cpu_dat[1:0]);
          SS_CMD:  cmd_d    = cmd_e'(cpu_dat[3:0]);
          default: ;
        endcase
      end
    end
  end

  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      cmd_q    <= CMD_CHR0;
      mirror_q <= MIR_VERT;
      reg8_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) chr_q[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) prg_q[i] <= '0;
    end else begin
      cmd_q    <= cmd_d;
      mirror_q <= mirror_d;
      reg8_q   <= reg8_d;
      chr_q    <= chr_d;
      prg_q    <= prg_d;
    end
  end

  fme7_irq u_irq (
    .clk_i     (m2),
    .rst_ni    (map_rst_n),
    .freeze_i  (ss_act),
    .ctrl_we_i (ctrl_we),
    .lo_we_i   (lo_we),
    .hi_we_i   (hi_we),
    .st_we_i   (st_we),
    .wdat_i    (cpu_dat),
    .cnt_o     (cnt),
    .ctrl7_o   (ctrl7),
    .ctrl0_o   (ctrl0),
    .pend_o    (pend),
    .irq_o     (irq)
  );

  // Banks are widened to 32 bits so any address width can take its low slice.
  always_comb begin
    prg_ext = {26'd0, reg8_q[5:0]};
    if (cpu_addr[15]) begin
      case (cpu_addr[14:13])
        2'd0:    prg_ext = {24'd0, prg_q[0]};
        2'd1:    prg_ext = {24'd0, prg_q[1]};
        2'd2:    prg_ext = {24'd0, prg_q[2]};
        default: prg_ext = '1;
      endcase
    end
  end

  assign chr_ext  = {24'd0, chr_q[ppu_addr[12:10]]};
  assign prg_addr = {prg_ext[PB-1:0], cpu_addr[12:0]};
  assign chr_addr = {chr_ext[CB-1:0], ppu_addr[9:0]};
  assign wram_win = (cpu_addr[15:13] == 3'b011);

`ifdef MAP069_WRAM_EN
  assign rom_ce = cpu_addr[15] || (wram_win && !reg8_q[6]);
  assign ram_ce = wram_win && reg8_q[6] && reg8_q[7];
  assign ram_we = ram_ce && !cpu_rw;
`else
  assign rom_ce = cpu_addr[15] || wram_win;
  assign ram_ce = 1'b0;
  assign ram_we = 1'b0;
`endif

  always_comb begin
    case (mirror_q)
      MIR_VERT: ciram_a10 = ppu_addr[10];
      MIR_HORZ: ciram_a10 = ppu_addr[11];
      MIR_ONE0: ciram_a10 = 1'b0;
      default:  ciram_a10 = 1'b1;
    endcase
  end
  assign ciram_ce = !ppu_addr[13];

  always_comb begin
    ss_rdat = 8'hFF;
    if (ss_addr < 8'd8) begin
      ss_rdat = chr_q[ss_addr[2:0]];
    end else begin
      case (ss_addr)
        SS_PRG6:   ss_rdat = reg8_q;
        SS_PRG8:   ss_rdat = prg_q[0];
        SS_PRGA:   ss_rdat = prg_q[1];
        SS_PRGC:   ss_rdat = prg_q[2];
        SS_CTRL:   ss_rdat = {3'b000, ctrl7, ctrl0, pend, mirror_q};
        SS_CMD:    ss_rdat = {4'h0, cmd_q};
        SS_CNT_LO: ss_rdat = cnt[7:0];
        SS_CNT_HI: ss_rdat = cnt[15:8];
        SS_ID:     ss_rdat = MAPPER_ID;
        default:   ss_rdat = 8'hFF;
      endcase
    end
  end

  // PPU read strobe plays no part in address generation.
  assign unused_ok = ^{ppu_oe, prg_ext, chr_ext};

endmodule
